ysyx_25050147_ifu: RTL and testbench

Instruction fetch unit. It is the producer side of the decode interface: it supplies the 32-bit instruction word and its PC to the decoder.
- Owns the architectural PC.
- Issues single-outstanding read requests on a valid/ready instruction-memory port.
- Buffers one returned instruction and presents it to decode with a valid/ready handshake.
- Accepts jump redirects from execute and a halt (ebreak) from the core.

---
 rtl/ysyx_25050147_pkg.sv | 19 +
 rtl/ysyx_25050147_ifu_pcgen.sv | 38 +++
 rtl/ysyx_25050147_ifu.sv | 118 +++++++++++
 tb/tb_ysyx_25050147_ifu.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25050147_pkg.sv
// Shared types and constants for the ysyx_25050147 fetch path.
// Holds the IFU state encoding, bus widths and the reset PC.
package ysyx_25050147_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0]   RESET_PC_DEF = 32'h8000_0000;
  localparam logic [INST_W-1:0] EBREAK       = 32'h0010_0073;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALT
  } ifu_state_e;

endpackage

// File: rtl/ysyx_25050147_ifu_pcgen.sv
// Next-PC mux: redirect over increment over hold; purely combinational.
// IFU_ALIGN_CHECK_EN flags misaligned redirect targets instead of truncating them.
module ysyx_25050147_ifu_pcgen
  import ysyx_25050147_pkg::*;
#(
  parameter int PC_STEP = 4
) (
  input  logic [XLEN-1:0] pc,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);

  logic [XLEN-1:0] target;

`ifdef IFU_ALIGN_CHECK_EN
  assign misalign = redirect_en && (redirect_pc[1:0] != 2'b00);
  assign target   = redirect_pc;
`else
  logic unused_lo;
  assign unused_lo = ^redirect_pc[1:0];
  assign misalign  = 1'b0;
  assign target    = {redirect_pc[XLEN-1:2], 2'b00};
`endif

  always_comb begin
    next_pc = pc;
    if (redirect_en) begin
      // A faulting target leaves the PC untouched.
      if (!misalign) next_pc = target;
    end else if (advance) begin
      next_pc = pc + XLEN'(PC_STEP);
    end
  end

endmodule

// File: rtl/ysyx_25050147_ifu.sv
// Instruction fetch unit: single-outstanding imem requests, one-entry buffer to decode.
// Zero-wait memory gives inst_valid 3 cycles after reset; optional IFU_ALIGN_CHECK_EN adds fetch_fault.
module ysyx_25050147_ifu
  import ysyx_25050147_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt
`ifdef IFU_ALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  ifu_state_e      state, state_n;
  logic [XLEN-1:0] pc, pc_n, inst_q, inst_pc_q;
  logic            discard, discard_n, halted, halted_n;
  logic            redir_act, misalign, stop, req_hs, advance, rsp_take;

  assign redir_act = redirect_valid && (state == REQ || state == WAIT || state == HOLD);
  // A misaligned redirect behaves like a halt; halted keeps it sticky.
  assign stop      = halt || halted || misalign;
  assign req_hs    = (state == REQ) && imem_req_ready;
  assign advance   = (state == HOLD) && inst_ready && !stop;
  assign rsp_take  = (state == WAIT) && imem_rsp_valid && !discard && !redir_act && !stop;

  ysyx_25050147_ifu_pcgen #(.PC_STEP(PC_STEP)) u_pcgen (
    .pc          (pc),
    .redirect_en (redir_act),
    .redirect_pc (redirect_pc),
    .advance     (advance),
    .next_pc     (pc_n),
    .misalign    (misalign)
  );

  always_comb begin
    state_n   = state;
    discard_n = discard;
    halted_n  = halted || halt || misalign;
    unique case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (req_hs) begin
          state_n   = WAIT;
          discard_n = redir_act || stop;
        end else if (stop) begin
          state_n = HALT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          discard_n = 1'b0;
          if (stop)                        state_n = HALT;
          else if (discard || redir_act)   state_n = REQ;
          else                             state_n = HOLD;
        end else if (redir_act || stop) begin
          discard_n = 1'b1;
        end
      end
      HOLD: begin
        if (stop)                           state_n = HALT;
        else if (redir_act || inst_ready)   state_n = REQ;
      end
      HALT: state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      discard   <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      discard <= discard_n;
      halted  <= halted_n;
      if (rsp_take) begin
        inst_q    <= imem_rsp_data;
        inst_pc_q <= pc;
      end
    end
  end

`ifdef IFU_ALIGN_CHECK_EN
  logic fault_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        fault_q <= 1'b0;
    else if (misalign) fault_q <= 1'b1;
  end
  assign fetch_fault = fault_q;
`endif

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = (state == REQ) ? pc : '0;
  assign inst_valid     = (state == HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_ysyx_25050147_ifu.sv
// Directed bench for ysyx_25050147_ifu with a zero-wait memory responder.
// Build with IFU_ALIGN_CHECK_EN defined to cover the fetch_fault path.
module tb_ysyx_25050147_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
`ifdef IFU_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] req_log[$];
  logic [31:0] ipc_log[$];
  logic [31:0] idat_log[$];
  logic        ovr_en;
  logic [31:0] ovr_addr, ovr_data;

  ysyx_25050147_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
`ifdef IFU_ALIGN_CHECK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory model and decode monitor: accept seen mid-cycle, response one cycle later.
  initial begin
    logic        acc;
    logic [31:0] acc_addr;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      acc      = rst_n && imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      if (acc) req_log.push_back(acc_addr);
      if (rst_n && inst_valid && inst_ready) begin
        ipc_log.push_back(inst_pc);
        idat_log.push_back(inst);
      end
      @(posedge clk); #1;
      imem_rsp_valid = acc;
      imem_rsp_data  = !acc ? 32'h0 : (ovr_en && acc_addr == ovr_addr) ? ovr_data : mem_word(acc_addr);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    halt = 1'b0; imem_req_ready = 1'b1; ovr_en = 1'b0; ovr_addr = '0; ovr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    req_log.delete(); ipc_log.delete(); idat_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input logic [31:0] a);
    int cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(imem_req_valid && imem_req_addr === a) && cnt < 60);
    n_checks++;
    if (!(imem_req_valid && imem_req_addr === a)) begin
      n_fail++; $display("FAIL wait_req: no request to %h, last addr %h", a, imem_req_addr);
    end
  endtask

  task automatic wait_inst(input int n);
    int cnt = 0;
    while (ipc_log.size() < n && cnt < 60) begin tick(); cnt++; end
    n_checks++;
    if (ipc_log.size() < n) begin
      n_fail++; $display("FAIL wait_inst: got %0d instructions, need %0d", ipc_log.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    halt = 1'b0; imem_req_ready = 1'b1; ovr_en = 1'b0;
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    n_checks++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL rst_req_addr: got %h want 0", imem_req_addr); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
    n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h want 0", inst); end
    n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL rst_inst_pc: got %h want 0", inst_pc); end
`ifdef IFU_ALIGN_CHECK_EN
    n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b want 0", fetch_fault); end
`endif
  endtask

  task automatic test_fetch();
    do_reset();
    inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (inst_valid !== (k == 3)) begin n_fail++; $display("FAIL first_valid cyc%0d: got %b want %b", k, inst_valid, k == 3); end
      if (k == 1) begin
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
          n_fail++; $display("FAIL first_req: got v=%b a=%h want v=1 a=80000000", imem_req_valid, imem_req_addr);
        end
      end
    end
    wait_inst(3);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'h8000_0000 + 32'(4 * i);
      n_checks++; if (req_log[i] !== exp_pc) begin n_fail++; $display("FAIL fetch_addr%0d: got %h want %h", i, req_log[i], exp_pc); end
      n_checks++; if (ipc_log[i] !== exp_pc) begin n_fail++; $display("FAIL fetch_pc%0d: got %h want %h", i, ipc_log[i], exp_pc); end
      n_checks++; if (idat_log[i] !== mem_word(exp_pc)) begin n_fail++; $display("FAIL fetch_dat%0d: got %h want %h", i, idat_log[i], mem_word(exp_pc)); end
    end
  endtask

  task automatic test_stall();
    int cnt = 0;
    do_reset();
    do begin @(negedge clk); cnt++; end while (!inst_valid && cnt < 20);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++;
      if (inst_valid !== 1'b1 || inst !== mem_word(32'h8000_0000) || inst_pc !== 32'h8000_0000) begin
        n_fail++; $display("FAIL stall_hold%0d: got v=%b i=%h pc=%h want v=1 i=%h pc=80000000", i, inst_valid, inst, inst_pc, mem_word(32'h8000_0000));
      end
      n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_noreq%0d: got %b want 0", i, imem_req_valid); end
    end
    n_checks++; if (req_log.size() != 1) begin n_fail++; $display("FAIL stall_reqcnt: got %0d want 1", req_log.size()); end
    tick();
    inst_ready = 1'b1;
    wait_inst(2);
    n_checks++; if (req_log[1] !== 32'h8000_0004) begin n_fail++; $display("FAIL stall_next: got %h want 80000004", req_log[1]); end
    n_checks++; if (ipc_log[1] !== 32'h8000_0004) begin n_fail++; $display("FAIL stall_pc1: got %h want 80000004", ipc_log[1]); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    inst_ready = 1'b1; ovr_en = 1'b1; ovr_addr = 32'h8000_0004; ovr_data = 32'h0000_0013;
    wait_req(32'h8000_0004);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    wait_inst(2);
    n_checks++; if (req_log[2] !== 32'h8000_0100) begin n_fail++; $display("FAIL rw_addr: got %h want 80000100", req_log[2]); end
    n_checks++; if (ipc_log[1] !== 32'h8000_0100) begin n_fail++; $display("FAIL rw_pc: got %h want 80000100", ipc_log[1]); end
    n_checks++; if (idat_log[1] !== mem_word(32'h8000_0100)) begin n_fail++; $display("FAIL rw_dat: got %h want %h", idat_log[1], mem_word(32'h8000_0100)); end
    foreach (idat_log[i]) begin
      n_checks++; if (idat_log[i] === 32'h0000_0013) begin n_fail++; $display("FAIL rw_dropped: got %h at slot %0d want no such word", idat_log[i], i); end
    end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    inst_ready = 1'b1;
    wait_req(32'h8000_0000);
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL rh_inhold: got %b want 1", inst_valid); end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rh_drop: got %b want 0", inst_valid); end
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin
      n_fail++; $display("FAIL rh_req: got v=%b a=%h want v=1 a=80000200", imem_req_valid, imem_req_addr);
    end
    wait_inst(2);
    n_checks++; if (ipc_log[0] !== 32'h8000_0000) begin n_fail++; $display("FAIL rh_pc0: got %h want 80000000", ipc_log[0]); end
    n_checks++; if (ipc_log[1] !== 32'h8000_0200) begin n_fail++; $display("FAIL rh_pc1: got %h want 80000200", ipc_log[1]); end
  endtask

  task automatic test_redirect_req();
    do_reset();
    inst_ready = 1'b1; imem_req_ready = 1'b0;
    wait_req(32'h8000_0000);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0040;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (imem_req_addr !== 32'h8000_0040) begin n_fail++; $display("FAIL rq_addr: got %h want 80000040", imem_req_addr); end
    n_checks++; if (req_log.size() != 0) begin n_fail++; $display("FAIL rq_noacc: got %0d accepts want 0", req_log.size()); end
    tick();
    imem_req_ready = 1'b1;
    wait_inst(1);
    n_checks++; if (ipc_log[0] !== 32'h8000_0040) begin n_fail++; $display("FAIL rq_pc: got %h want 80000040", ipc_log[0]); end
  endtask

  task automatic test_halt();
    do_reset();
    inst_ready = 1'b1;
    wait_req(32'h8000_0004);
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        n_fail++; $display("FAIL halt_quiet%0d: got req=%b inst=%b want 0/0", i, imem_req_valid, inst_valid);
      end
    end
    tick();
    n_checks++; if (req_log.size() != 2) begin n_fail++; $display("FAIL halt_reqcnt: got %0d want 2", req_log.size()); end
    n_checks++; if (ipc_log.size() != 1) begin n_fail++; $display("FAIL halt_instcnt: got %0d want 1", ipc_log.size()); end
    do_reset();
    inst_ready = 1'b1;
    wait_req(32'h8000_0000);
    wait_inst(1);
    n_checks++; if (ipc_log[0] !== 32'h8000_0000) begin n_fail++; $display("FAIL halt_restart: got %h want 80000000", ipc_log[0]); end
  endtask

`ifdef IFU_ALIGN_CHECK_EN
  task automatic test_align();
    do_reset();
    inst_ready = 1'b1;
    wait_req(32'h8000_0000);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL align_fault: got %b want 1", fetch_fault); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        n_fail++; $display("FAIL align_quiet%0d: got req=%b inst=%b want 0/0", i, imem_req_valid, inst_valid);
      end
    end
    tick();
    n_checks++; if (req_log.size() != 1) begin n_fail++; $display("FAIL align_reqcnt: got %0d want 1", req_log.size()); end
    n_checks++; if (ipc_log.size() != 0) begin n_fail++; $display("FAIL align_instcnt: got %0d want 0", ipc_log.size()); end
  endtask
`else
  task automatic test_align();
    do_reset();
    imem_req_ready = 1'b0;
    wait_req(32'h8000_0000);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (imem_req_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL align_trunc: got %h want 80000100", imem_req_addr); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_req();
    test_halt();
    test_align();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
